// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result handshake bundle for serial_subtractor_ctrl.
// The master side issues start with operands; the slave side reports busy/done and the difference.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, result, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell walked LSB-first, borrow held in a flop.
// Define SERIAL_SUB_SAT_EN to clamp an underflowing result to zero (borrow_out still reports it).
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             busy_c;
  logic             done_c;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             bin;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] diff_full;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign d    = a_sh[0] ^ b_sh[0] ^ bin;
  assign bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);

  // a_sh doubles as the difference accumulator: each difference bit enters at the MSB
  // as the consumed minuend bit leaves at the LSB.
  assign diff_full = {d, a_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (count == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      bin      <= 1'b0;
      count    <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      bin   <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= diff_full;
      b_sh  <= b_sh >> 1;
      bin   <= bout;
      count <= count + CW'(1);
      // Visible outputs change only on the edge that enters DONE.
      if (count == LAST) begin
        borrow_q <= bout;
`ifdef SERIAL_SUB_SAT_EN
        result_q <= bout ? '0 : diff_full;
`else
        result_q <= diff_full;
`endif
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.result     = result_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8; honours SERIAL_SUB_SAT_EN in its model.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         brw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.res = av - bv;
    e.brw = (av < bv);
`ifdef SERIAL_SUB_SAT_EN
    if (e.brw) e.res = '0;
`endif
    return e;
  endfunction

  // Drives one start cycle from a negedge; returns at the next negedge with the op in RUN.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit track);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    if (track) sb.push_back(model(av, bv));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic wait_done(input int limit, output int cycles, output int busy_cycles,
                           output bit found, output bit res_changed);
    logic [W-1:0] res0;
    res0        = bus.result;
    found       = 1'b0;
    cycles      = 0;
    busy_cycles = 0;
    res_changed = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done === 1'b1) begin
        found  = 1'b1;
        cycles = i;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.result !== res0) res_changed = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.borrow_out, bus.result} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_held: busy=%b done=%b borrow=%b result=%h expected all zero",
               bus.busy, bus.done, bus.borrow_out, bus.result);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.borrow_out, bus.result} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b done=%b borrow=%b result=%h expected all zero",
               bus.busy, bus.done, bus.borrow_out, bus.result);
    end
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    bit found, chg;
    exp_t e;
    applyStimulus(8'h5A, 8'h3C, 1'b1);
    wait_done(20, cyc, bcyc, found, chg);
    checks++;
    if (!found || cyc != 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: found=%0d cycles=%0d expected done after 8", found, cyc);
    end
    checks++;
    if (bcyc != 8) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles expected 8", bcyc);
    end
    checks++;
    if (chg) begin
      errors++;
      $display("[TB] FAIL basic_result_stable: result moved during RUN, expected held");
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (bus.result !== e.res || bus.borrow_out !== e.brw) begin
      errors++;
      $display("[TB] FAIL basic_value: got %h/%b expected %h/%b", bus.result, bus.borrow_out, e.res, e.brw);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== e.res) begin
      errors++;
      $display("[TB] FAIL basic_after_done: done=%b busy=%b result=%h expected 0/0/%h",
               bus.done, bus.busy, bus.result, e.res);
    end
  endtask

  task automatic test_wrap();
    int cyc, bcyc;
    bit found, chg;
    exp_t e;
    applyStimulus(8'h03, 8'h05, 1'b1);
    wait_done(20, cyc, bcyc, found, chg);
    checks++;
    if (!found || chg) begin
      errors++;
      $display("[TB] FAIL wrap_done: found=%0d result_changed=%0d expected 1/0", found, chg);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (bus.result !== e.res || bus.borrow_out !== e.brw) begin
      errors++;
      $display("[TB] FAIL wrap_value: got %h/%b expected %h/%b", bus.result, bus.borrow_out, e.res, e.brw);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int ndone;
    exp_t e;
    logic [W-1:0] res_at_done;
    logic brw_at_done;
    ndone       = 0;
    res_at_done = 'x;
    brw_at_done = 1'bx;
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          res_at_done = bus.result;
          brw_at_done = bus.borrow_out;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("[TB] FAIL ignore_done_count: got %0d done pulses expected 1", ndone);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (res_at_done !== e.res || brw_at_done !== e.brw) begin
      errors++;
      $display("[TB] FAIL ignore_value: got %h/%b expected %h/%b", res_at_done, brw_at_done, e.res, e.brw);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, last, busy_err;
    exp_t e;
    ndone    = 0;
    last     = -1;
    busy_err = 0;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    sb.push_back(model(8'h10, 8'h01));
    for (int t = 0; t < 40 && ndone < 3; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (bus.busy !== 1'b0) busy_err++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (bus.result !== e.res || bus.borrow_out !== e.brw) begin
          errors++;
          $display("[TB] FAIL b2b_value_%0d: got %h/%b expected %h/%b",
                   ndone, bus.result, bus.borrow_out, e.res, e.brw);
        end
        if (last >= 0) begin
          checks++;
          if (t - last != 9) begin
            errors++;
            $display("[TB] FAIL b2b_period_%0d: got %0d cycles expected 9", ndone, t - last);
          end
        end
        last = t;
        if (ndone < 3) sb.push_back(model(8'h10, 8'h01));
        else bus.start = 1'b0;
      end else if (bus.busy !== 1'b1) begin
        busy_err++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 3 || busy_err != 0) begin
      errors++;
      $display("[TB] FAIL b2b_stream: got %0d dones, %0d busy glitches expected 3/0", ndone, busy_err);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ndone, cyc, bcyc;
    bit found, chg;
    exp_t e;
    ndone = 0;
    applyStimulus(8'h80, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.borrow_out, bus.result} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: busy=%b done=%b borrow=%b result=%h expected all zero",
               bus.busy, bus.done, bus.borrow_out, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", ndone);
    end
    applyStimulus(8'h80, 8'h01, 1'b1);
    wait_done(20, cyc, bcyc, found, chg);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (!found || bus.result !== e.res || bus.borrow_out !== e.brw) begin
      errors++;
      $display("[TB] FAIL abort_fresh_op: found=%0d got %h/%b expected %h/%b",
               found, bus.result, bus.borrow_out, e.res, e.brw);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
